async_fifo_wptr_full: RTL and testbench
=======================================

Name: async_fifo_wptr_full

Overview:
- Write-domain pointer and status generator for the asynchronous FIFO.
- Maintains the binary and Gray write pointers and produces the memory write address and write enable.
- Drives the Gray write pointer into the write-to-read 2-flop synchronizer.
- Consumes the read pointer after it has been synchronized into the write domain, and from it generates full, almost-full, fill level and overflow status.

Parameters:
- ADDRSIZE, 4: memory address width. DEPTH = 2**ADDRSIZE. Pointers are ADDRSIZE+1 bits wide.
- AFULL_SLOTS, 2: walmost_full asserts when free slots <= AFULL_SLOTS. Legal range 1..DEPTH-1.

Ports:
- clk  input  1  write-domain clock.
- rst  input  1  reset, synchronous, active-high.
- winc  input  1  write request from the producer.
- wq2_rptr  input  ADDRSIZE+1  Gray read pointer, already synchronized into the clk domain.
- wen  output  1  memory write enable; combinational, equal to winc & ~wfull.
- waddr  output  ADDRSIZE  memory write address; equal to the low ADDRSIZE bits of the binary write pointer.
- wptr  output  ADDRSIZE+1  registered Gray write pointer, sent to the synchronizer.
- wfull  output  1  registered full flag.
- walmost_full  output  1  registered almost-full flag.
- wlevel  output  ADDRSIZE+1  registered fill level, range 0..DEPTH.
- woverflow  output  1  sticky error flag; set on a write attempt while full.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Binary pointer wbin, wptr, wfull, walmost_full, wlevel and woverflow all go to 0.
  - Reset takes priority over all other inputs, including mid-burst.
- Next-state pointers, computed every cycle:
  - wbinnext = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
  - Registered: wbin <= wbinnext and wptr <= wgraynext.
  - wptr changes by exactly one bit per accepted write and never glitches, because it is a pure register output.
- Write acceptance:
  - wen is high in the same cycle as winc when wfull=0.
  - The memory captures data at that edge, at address waddr (the pre-increment value).
- Full:
  - wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - wfull asserts on the same edge that accepts the DEPTH-th unread word.
  - wfull deasserts one clk after wq2_rptr advances.
  - wfull is pessimistic: up to 3 clk after a real read, counting the 2 synchronizer flops and this register.
- Level:
  - rq2_bin is the Gray-to-binary conversion of wq2_rptr, computed combinationally as an XOR prefix from the MSB down.
  - wlevel <= (wbinnext - rq2_bin), modulo 2**(ADDRSIZE+1).
  - wlevel reaches DEPTH exactly when wfull=1.
- Almost-full:
  - walmost_full <= ((wbinnext - rq2_bin) >= DEPTH - AFULL_SLOTS).
  - It is a superset of wfull and updates on the same edge.
- Overflow:
  - woverflow <= 1 when winc=1 and wfull=1.
  - It stays 1 until reset, and the pointer does not move.
- Wrap-around: the pointer wraps from 2**(ADDRSIZE+1)-1 to 0. The MSB toggle distinguishes full from empty.
- Simultaneous events: a write accepted in the same cycle that wq2_rptr advances uses both new values. Level, full and almost-full are computed from wbinnext and the current wq2_rptr.
- Latency: accepted write to wptr update is 1 clk, and to status update is 1 clk.

Test Plan:
- Reset with winc=1 held for 3 cycles -> wptr=0, wlevel=0, wfull=0, wen gated by nothing but wfull. Writes resume the cycle after rst drops.
- 16 consecutive writes with wq2_rptr=0, ADDRSIZE=4:
  - wptr steps through the Gray sequence 00001, 00011, 00010, ..., 11000.
  - walmost_full asserts after the 14th write (wlevel=14).
  - wfull=1 after the 16th write (wlevel=16).
- Full, then winc=1 for 2 cycles -> wen=0, wptr stays 11000, woverflow=1 and remains 1 until rst.
- From full, drive wq2_rptr=00001 (Gray of 1) -> next cycle wfull=0, wlevel=15, walmost_full=1. One write is accepted, then wfull=1 again.
- Wrap-around: perform 40 writes while tracking wq2_rptr 2 words behind -> wbin passes 31 to 0, wptr returns to 00000 after the 32nd write, and wfull never asserts.
- Assert rst while full with woverflow=1 -> all outputs 0 on the next edge, and the first following write gives waddr=0.

Source files
------------

// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer and status generator for the asynchronous FIFO.
// Keeps binary/Gray write pointers and derives full, almost-full, level and overflow.
module async_fifo_wptr_full #(
  parameter int unsigned ADDRSIZE    = 4,
  parameter int unsigned AFULL_SLOTS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int unsigned PW    = ADDRSIZE + 1;
  localparam int unsigned DEPTH = 1 << ADDRSIZE;
  localparam logic [PW-1:0] AFULL_THR = PW'(DEPTH - AFULL_SLOTS);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbinnext;
  logic [PW-1:0] wgraynext;
  logic [PW-1:0] rq2_bin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_cmp;
  logic          accept;

  assign accept = winc & ~wfull;
  assign wen    = accept;
  assign waddr  = wbin[ADDRSIZE-1:0];

  assign wbinnext   = wbin + PW'(accept);
  assign wgraynext  = (wbinnext >> 1) ^ wbinnext;
  assign level_next = wbinnext - rq2_bin;

  // Full when the next write pointer equals the read pointer with its top two Gray bits inverted.
  assign full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    rq2_bin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rq2_bin[i] = ^(wq2_rptr >> i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= (wgraynext == full_cmp);
      walmost_full <= (level_next >= AFULL_THR);
      wlevel       <= level_next;
      // Sticky until reset so a dropped write is never lost from view.
      woverflow    <= woverflow | (winc & wfull);
    end
  end

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Directed bench for async_fifo_wptr_full: reset, fill to full, overflow,
// drain-by-one, reset while full, and pointer wrap-around.
module tb_async_fifo_wptr_full;

  logic       clk;
  logic       rst;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int n_checks = 0;
  int n_fail   = 0;

  async_fifo_wptr_full #(.ADDRSIZE(4), .AFULL_SLOTS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] gray(input int unsigned b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wptr"}, 32'(wptr), 32'd0);
    chk({tag, ".wlevel"}, 32'(wlevel), 32'd0);
    chk({tag, ".wfull"}, 32'(wfull), 32'd0);
    chk({tag, ".walmost_full"}, 32'(walmost_full), 32'd0);
    chk({tag, ".woverflow"}, 32'(woverflow), 32'd0);
    chk({tag, ".waddr"}, 32'(waddr), 32'd0);
  endtask

  initial begin
    int unsigned rd;
    rst      = 1'b1;
    winc     = 1'b1;
    wq2_rptr = 5'd0;

    // Reset held with writes requested.
    step(); step(); step();
    chk_all_zero("reset");
    chk("reset.wen", 32'(wen), 32'd1);

    // Fill with 16 writes, read pointer held at 0.
    rst = 1'b0;
    #1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("fill%0d.wen", i), 32'(wen), 32'd1);
      chk($sformatf("fill%0d.waddr", i), 32'(waddr), 32'(i - 1));
      step();
      chk($sformatf("fill%0d.wptr", i), 32'(wptr), 32'(gray(i)));
      chk($sformatf("fill%0d.wlevel", i), 32'(wlevel), 32'(i));
      chk($sformatf("fill%0d.afull", i), 32'(walmost_full), 32'(i >= 14));
      chk($sformatf("fill%0d.wfull", i), 32'(wfull), 32'(i == 16));
    end
    chk("full.wptr_const", 32'(wptr), 32'h18);

    // Writes while full are dropped and flagged.
    chk("ovf.wen", 32'(wen), 32'd0);
    step();
    chk("ovf1.woverflow", 32'(woverflow), 32'd1);
    chk("ovf1.wptr", 32'(wptr), 32'h18);
    step();
    chk("ovf2.wen", 32'(wen), 32'd0);
    chk("ovf2.wptr", 32'(wptr), 32'h18);
    chk("ovf2.wfull", 32'(wfull), 32'd1);
    chk("ovf2.wlevel", 32'(wlevel), 32'd16);

    // One word read: full releases, one more write refills.
    winc     = 1'b0;
    wq2_rptr = 5'b00001;
    step();
    chk("drain.wfull", 32'(wfull), 32'd0);
    chk("drain.wlevel", 32'(wlevel), 32'd15);
    chk("drain.afull", 32'(walmost_full), 32'd1);
    chk("drain.woverflow", 32'(woverflow), 32'd1);
    winc = 1'b1;
    #1;
    chk("refill.wen", 32'(wen), 32'd1);
    chk("refill.waddr", 32'(waddr), 32'd0);
    step();
    chk("refill.wfull", 32'(wfull), 32'd1);
    chk("refill.wlevel", 32'(wlevel), 32'd16);
    chk("refill.wptr", 32'(wptr), 32'h19);

    // Reset while full with overflow set.
    rst = 1'b1;
    step();
    chk_all_zero("rstfull");
    rst = 1'b0;
    wq2_rptr = 5'd0;
    #1;
    chk("postrst.wen", 32'(wen), 32'd1);
    chk("postrst.waddr", 32'(waddr), 32'd0);
    step();
    chk("postrst.wptr", 32'(wptr), 32'h01);
    chk("postrst.wlevel", 32'(wlevel), 32'd1);

    // Wrap-around: 40 writes with the read pointer trailing by 2 words.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      rd = (i >= 3) ? 32'(i - 3) : 32'd0;
      wq2_rptr = gray(rd % 32);
      #1;
      chk($sformatf("wrap%0d.waddr", i), 32'(waddr), 32'((i - 1) % 16));
      step();
      chk($sformatf("wrap%0d.wptr", i), 32'(wptr), 32'(gray(i % 32)));
      chk($sformatf("wrap%0d.wlevel", i), 32'(wlevel), 32'(i - rd));
      chk($sformatf("wrap%0d.wfull", i), 32'(wfull), 32'd0);
      chk($sformatf("wrap%0d.afull", i), 32'(walmost_full), 32'd0);
      if (i == 32) chk("wrap32.wptr_zero", 32'(wptr), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
